// File: rtl/pong_pkg.sv
// pong_pkg: shared state encoding and datapath widths for the pong game-flow logic.
package pong_pkg;
    localparam int SPEED_W = 4;
    localparam int SCORE_W = 8;
    localparam int LIVES_W = 2;
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SERVE,
        ST_PLAY,
        ST_PAUSED,
        ST_MISS,
        ST_OVER
    } state_t;
endpackage

// File: rtl/edge_pulse.sv
// edge_pulse: registers a level and emits a one-cycle rise (FALL=0) or fall (FALL=1) pulse.
module edge_pulse #(
    parameter bit FALL = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_pulse
);
    logic r_q, r_p;
    // Reset loads both stages with the live input so no edge is seen right after reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_q <= i_d;
            r_p <= i_d;
        end else begin
            r_q <= i_d;
            r_p <= r_q;
        end
    end
    assign o_pulse = FALL ? (r_p & ~r_q) : (r_q & ~r_p);
endmodule

// File: rtl/pong_sequencer.sv
// pong_sequencer: game-flow FSM turning start/hit/miss and vsync into serve, speed, score and lives.
// Define PONG_PAUSE_EN to add the PAUSED state toggled by the start button during play.
module pong_sequencer
    import pong_pkg::*;
#(
    parameter int LIVES            = 3,
    parameter int HITS_PER_SPEEDUP = 4,
    parameter int SERVE_FRAMES     = 60,
    parameter int MISS_FRAMES      = 30
) (
    input  logic               vclock,
    input  logic               reset,
    input  logic               vsync,
    input  logic               start,
    input  logic               hit,
    input  logic               miss,
    input  logic [SPEED_W-1:0] base_speed,
    output logic               ball_run,
    output logic               serve,
    output logic [SPEED_W-1:0] speed,
    output logic [SCORE_W-1:0] score,
    output logic [LIVES_W-1:0] lives,
    output logic               game_over,
    output logic               frame_tick
);
    logic w_start_ev, w_vs_fall;
    logic [3:0] w_hits_nx;
    logic w_speedup;
    state_t r_state;
    logic [7:0] r_cnt;
    logic [3:0] r_hits;
    logic r_ball_run, r_serve, r_game_over, r_frame_tick;
    logic [SPEED_W-1:0] r_speed;
    logic [SCORE_W-1:0] r_score;
    logic [LIVES_W-1:0] r_lives;

    edge_pulse #(.FALL(1'b0)) u_start (.i_clk(vclock), .i_rst(reset), .i_d(start), .o_pulse(w_start_ev));
    edge_pulse #(.FALL(1'b1)) u_vsync (.i_clk(vclock), .i_rst(reset), .i_d(vsync), .o_pulse(w_vs_fall));

    assign w_hits_nx = r_hits + 4'd1;
    assign w_speedup = w_hits_nx == 4'(HITS_PER_SPEEDUP);

    always_ff @(posedge vclock) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_hits       <= '0;
            r_ball_run   <= 1'b0;
            r_serve      <= 1'b0;
            r_speed      <= '0;
            r_score      <= '0;
            r_lives      <= LIVES_W'(LIVES);
            r_game_over  <= 1'b0;
            r_frame_tick <= 1'b0;
        end else begin
            r_frame_tick <= w_vs_fall;
            r_serve      <= 1'b0;
            case (r_state)
                ST_IDLE, ST_OVER:
                    if (w_start_ev) begin
                        r_score     <= '0;
                        r_lives     <= LIVES_W'(LIVES);
                        r_cnt       <= 8'(SERVE_FRAMES);
                        r_game_over <= 1'b0;
                        r_state     <= ST_SERVE;
                    end
                ST_SERVE:
                    if (r_frame_tick) begin
                        if (r_cnt == 8'd1) begin
                            r_serve    <= 1'b1;
                            r_speed    <= base_speed;
                            r_hits     <= '0;
                            r_ball_run <= 1'b1;
                            r_state    <= ST_PLAY;
                        end else
                            r_cnt <= r_cnt - 8'd1;
                    end
                // A miss wins over a simultaneous hit; the hit is dropped.
                ST_PLAY:
                    if (miss) begin
                        r_lives    <= r_lives - 2'd1;
                        r_ball_run <= 1'b0;
                        if (r_lives == 2'd1) begin
                            r_game_over <= 1'b1;
                            r_state     <= ST_OVER;
                        end else begin
                            r_cnt   <= 8'(MISS_FRAMES);
                            r_state <= ST_MISS;
                        end
                    end else if (hit) begin
                        r_score <= (r_score == '1) ? r_score : r_score + 8'd1;
                        r_hits  <= w_speedup ? 4'd0 : w_hits_nx;
                        if (w_speedup && r_speed != '1)
                            r_speed <= r_speed + 4'd1;
                    end
`ifdef PONG_PAUSE_EN
                    else if (w_start_ev) begin
                        r_ball_run <= 1'b0;
                        r_state    <= ST_PAUSED;
                    end
                ST_PAUSED:
                    if (w_start_ev) begin
                        r_ball_run <= 1'b1;
                        r_state    <= ST_PLAY;
                    end
`endif
                ST_MISS:
                    if (r_frame_tick) begin
                        if (r_cnt == 8'd1) begin
                            r_cnt   <= 8'(SERVE_FRAMES);
                            r_state <= ST_SERVE;
                        end else
                            r_cnt <= r_cnt - 8'd1;
                    end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign ball_run   = r_ball_run;
    assign serve      = r_serve;
    assign speed      = r_speed;
    assign score      = r_score;
    assign lives      = r_lives;
    assign game_over  = r_game_over;
    assign frame_tick = r_frame_tick;
endmodule

// File: tb/tb_pong_sequencer.sv
// tb_pong_sequencer: directed checks of serve timing, speedup, misses, game over and reset.
module tb_pong_sequencer;
    logic vclock = 1'b0, reset = 1'b1, vsync = 1'b1, start = 1'b0, hit = 1'b0, miss = 1'b0;
    logic [3:0] base_speed = 4'd5;
    logic ball_run, serve, game_over, frame_tick;
    logic [3:0] speed;
    logic [7:0] score;
    logic [1:0] lives;
    int n_chk = 0, n_bad = 0, n_serve = 0;

    pong_sequencer #(.LIVES(3), .HITS_PER_SPEEDUP(4), .SERVE_FRAMES(2), .MISS_FRAMES(3)) dut (
        .vclock(vclock), .reset(reset), .vsync(vsync), .start(start), .hit(hit), .miss(miss),
        .base_speed(base_speed), .ball_run(ball_run), .serve(serve), .speed(speed), .score(score),
        .lives(lives), .game_over(game_over), .frame_tick(frame_tick)
    );

    always #5 vclock = ~vclock;
    always @(posedge vclock) if (serve) n_serve++;

    task automatic chk(input string tag, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", tag, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge vclock);
        #1;
    endtask

    task automatic frames(input int n);
        repeat (n) begin
            vsync = 1'b0;
            step(2);
            vsync = 1'b1;
            step(4);
        end
    endtask

    task automatic hits(input int n);
        repeat (n) begin
            hit = 1'b1;
            step(1);
            hit = 1'b0;
            step(1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got 0 want 1");
        $fatal(1);
    end

    initial begin
        step(3);
        reset = 1'b0;
        step(1);
        chk("rst_ball_run", ball_run, 0);
        chk("rst_serve", serve, 0);
        chk("rst_speed", speed, 0);
        chk("rst_score", score, 0);
        chk("rst_lives", lives, 3);
        chk("rst_game_over", game_over, 0);
        chk("rst_frame_tick", frame_tick, 0);
        // reset in the middle of a serve countdown, start held high across it
        start = 1'b1;
        step(3);
        frames(1);
        reset = 1'b1;
        step(2);
        reset = 1'b0;
        step(1);
        chk("midrst_lives", lives, 3);
        chk("midrst_score", score, 0);
        chk("midrst_ball_run", ball_run, 0);
        frames(200);
        chk("idle_no_serve", n_serve, 0);
        chk("idle_ball_run", ball_run, 0);
        start = 1'b0;
        step(2);
        // serve after two frames
        start = 1'b1;
        step(3);
        chk("serve_wait_run", ball_run, 0);
        frames(1);
        chk("serve_early", n_serve, 0);
        vsync = 1'b0;
        step(2);
        chk("tick_high", frame_tick, 1);
        chk("serve_not_yet", serve, 0);
        step(1);
        chk("serve_pulse", serve, 1);
        chk("serve_ball_run", ball_run, 1);
        chk("serve_speed", speed, 5);
        vsync = 1'b1;
        step(1);
        chk("serve_one_cycle", serve, 0);
        step(2);
        start = 1'b0;
        step(2);
        chk("serve_count", n_serve, 1);
        hits(3);
        chk("hit3_score", score, 3);
        chk("hit3_speed", speed, 5);
        hits(1);
        chk("hit4_speed", speed, 6);
        hits(6);
        chk("hit10_score", score, 10);
        chk("hit10_speed", speed, 7);
        hit = 1'b1;
        miss = 1'b1;
        step(1);
        hit = 1'b0;
        miss = 1'b0;
        chk("both_score", score, 10);
        chk("both_lives", lives, 2);
        chk("both_ball_run", ball_run, 0);
        chk("both_game_over", game_over, 0);
        // three miss frames then two serve frames
        base_speed = 4'd14;
        frames(4);
        chk("miss_len_serves", n_serve, 1);
        chk("miss_len_run", ball_run, 0);
        frames(1);
        chk("reserve_count", n_serve, 2);
        chk("reserve_run", ball_run, 1);
        chk("reserve_speed", speed, 14);
        hits(2);
        chk("hitcnt_cleared", speed, 14);
        hits(2);
        chk("speed_sat1", speed, 15);
        hits(4);
        chk("speed_sat2", speed, 15);
        chk("score18", score, 18);
        miss = 1'b1;
        step(1);
        miss = 1'b0;
        step(1);
        chk("miss2_lives", lives, 1);
        chk("miss2_run", ball_run, 0);
        frames(5);
        chk("miss2_serve", n_serve, 3);
        miss = 1'b1;
        step(1);
        miss = 1'b0;
        step(1);
        chk("over_lives", lives, 0);
        chk("over_flag", game_over, 1);
        chk("over_run", ball_run, 0);
        hits(1);
        chk("over_score_held", score, 18);
        frames(5);
        chk("over_no_serve", n_serve, 3);
        chk("over_still", game_over, 1);
        // restart from OVER
        start = 1'b1;
        step(2);
        chk("restart_flag", game_over, 0);
        chk("restart_score", score, 0);
        chk("restart_lives", lives, 3);
        frames(2);
        chk("restart_serve", n_serve, 4);
        chk("restart_run", ball_run, 1);
        start = 1'b0;
        step(2);
        start = 1'b1;
        step(2);
`ifdef PONG_PAUSE_EN
        chk("pause_run", ball_run, 0);
        hits(1);
        chk("pause_hit_ignored", score, 0);
        start = 1'b0;
        step(2);
        start = 1'b1;
        step(2);
        chk("resume_run", ball_run, 1);
        step(2);
        chk("resume_no_serve", n_serve, 4);
`else
        chk("nopause_run", ball_run, 1);
        hits(1);
        chk("nopause_hit", score, 1);
`endif
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule

// File: doc/pong_sequencer.md
# pong_sequencer

Game-flow controller for the pong datapath on the 65 MHz video clock. Turns debounced button levels and hit/miss events from the ball/paddle logic into game states. Drives ball enable, serve strobe, ball speed, score and remaining lives. Sits between the debounce instances and `pong_game`, with XVGA `vsync` as its frame time base.

## Interface
Parameters:
- `LIVES`, 3: lives loaded at game start (1..3).
- `HITS_PER_SPEEDUP`, 4: paddle hits per speed increment (1..15).
- `SERVE_FRAMES`, 60: frames held in SERVE before launching (1..255).
- `MISS_FRAMES`, 30: frames held in MISS after a miss (1..255).

Ports:
- `vclock`  in  1: video clock, 65 MHz. Single clock domain.
- `reset`  in  1: synchronous, active-high.
- `vsync`  in  1: XVGA vertical sync, active-low.
- `start`  in  1: debounced start/pause button level.
- `hit`  in  1: one-cycle pulse, ball struck paddle.
- `miss`  in  1: one-cycle pulse, ball passed paddle.
- `base_speed`  in  4: starting speed (from switches), sampled at each serve.
- `ball_run`  out  1: ball motion enabled.
- `serve`  out  1: one-cycle pulse, recentre and launch ball.
- `speed`  out  4: current ball speed.
- `score`  out  8: hit count this game.
- `lives`  out  2: remaining lives.
- `game_over`  out  1: high in OVER.
- `frame_tick`  out  1: one-cycle pulse per frame.

## Operation
- **Frame tick:** `vsync` is registered once. `frame_tick` is asserted for the cycle after a registered 1→0 transition is seen.
- **Start event:** the rising edge of registered `start`, one cycle long.
- **States:** IDLE, SERVE, PLAY, PAUSED (only with `PAUSE_EN`), MISS, OVER.
- **IDLE:**
  - On a start event: `score`=0, `lives`=LIVES, frame counter=SERVE_FRAMES, go to SERVE.
- **SERVE:**
  - `ball_run`=0; the counter decrements on `frame_tick`.
  - When the counter is 1 and `frame_tick` occurs: pulse `serve`, load `speed`=`base_speed`, clear the hit counter, go to PLAY.
- **PLAY:**
  - `ball_run`=1.
  - `hit`: `score`+1, saturating at 255. The hit counter increments; when it reaches HITS_PER_SPEEDUP it clears and `speed`+1, saturating at 15.
  - `miss`: `lives`−1. If `lives` was 1, go to OVER; otherwise load the counter with MISS_FRAMES and go to MISS.
  - `hit` and `miss` in the same cycle: miss wins and the hit is discarded.
- **MISS:**
  - `ball_run`=0; the counter decrements on `frame_tick`.
  - At expiry: load the counter with SERVE_FRAMES and go to SERVE.
- **OVER:**
  - `game_over`=1; `score` and `lives` (0) are held.
  - A start event behaves exactly as in IDLE.
- **Ignored events:** `hit` and `miss` outside PLAY are ignored. A start event in SERVE or MISS is ignored.
- **Reset** at any cycle, including mid-countdown:
  - Next state IDLE.
  - `ball_run`=0, `serve`=0, `speed`=0, `score`=0, `lives`=LIVES, `game_over`=0, `frame_tick`=0.
  - Edge-detect registers load the current inputs, so no spurious event follows reset.

## Timing
- All outputs are registered.
- `serve` and the PLAY entry occur in the same cycle, one cycle after the expiring `frame_tick`. `ball_run` rises in that same cycle.
- `hit`/`miss` take effect on `score`/`speed`/`lives` one cycle later. The state change on a miss is also one cycle later.
- Start event latency: 2 cycles from the `start` rise to the state change.
- `frame_tick` latency: 2 cycles from the `vsync` fall.

## Configuration
- `PONG_PAUSE_EN` defined:
  - A start event in PLAY goes to PAUSED with `ball_run`=0; counters and the score are frozen.
  - A start event in PAUSED returns to PLAY without pulsing `serve`.
  - `hit`/`miss` are ignored in PAUSED.
- `PONG_PAUSE_EN` undefined: the PAUSED state is absent and a start event in PLAY is ignored.

## Structure
- Shared package `pong_pkg`: state enumeration encoding, speed width (4), score width (8), lives width (2).
- Sub-module `edge_pulse`: register plus rising/falling one-cycle pulse. It is instantiated for `start` (rise) and for `vsync` (fall).
- The frame counter and the hit counter live in the top FSM.

## Test plan
- **Reset:** assert `reset` mid-SERVE → state IDLE; `lives`=3; `score`=0; `ball_run`=0; no `serve` for 200 frames.
- **Serve:** start, SERVE_FRAMES=2, `base_speed`=5 → `serve` pulse exactly once, on the cycle after the 2nd `frame_tick`; `speed`=5; `ball_run`=1.
- **Speedup:** 8 `hit` pulses with HITS_PER_SPEEDUP=4, `base_speed`=14 → `score`=8, `speed`=15 (saturated after the first increment).
- **Miss and game over:** 3 `miss` pulses with serves between → `lives` 2, 1, 0; MISS lasts MISS_FRAMES frames; after the 3rd miss `game_over`=1 and no MISS state.
- **Simultaneous events:** `hit`+`miss` in the same cycle with `score`=10, `lives`=3 → `score`=10, `lives`=2, state MISS.
- **Pause (`PONG_PAUSE_EN`):** start in PLAY → `ball_run`=0 and `hit` ignored; start again → PLAY, no `serve` pulse.
